dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: IDLE/ACCESS/RESP handshake FSM
// with round-robin tie-break and a saturating conflict counter.
module dmem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [7:0]        conflict_cnt
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              win_q, win_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rd0_q, rd0_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              win;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      cnt_d   = cnt_q;
      win     = (r0_req && r1_req) ? ptr_q : r1_req;
      unique case (state_q)
         IDLE, RESP: begin
            if (r0_req || r1_req) begin
               state_d = ACCESS;
               win_d   = win;
               ptr_d   = ~win;
               we_d    = win ? r1_we    : r0_we;
               addr_d  = win ? r1_addr  : r0_addr;
               wdata_d = win ? r1_wdata : r0_wdata;
               if (r0_req && r1_req && cnt_q != 8'hFF)
                  cnt_d = cnt_q + 8'd1;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = RESP;
            // read data lands only in the winner's register
            if (!we_q) begin
               if (win_q) rd1_d = mem_rdata;
               else       rd0_d = mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         cnt_q   <= cnt_d;
      end
   end

   // all outputs decode flops only, so reset clears them at once
   assign r0_gnt       = (state_q == ACCESS) && !win_q;
   assign r1_gnt       = (state_q == ACCESS) &&  win_q;
   assign r0_rvalid    = (state_q == RESP) && !we_q && !win_q;
   assign r1_rvalid    = (state_q == RESP) && !we_q &&  win_q;
   assign mem_we       = (state_q == ACCESS) &&  we_q;
   assign mem_re       = (state_q == ACCESS) && !we_q;
   assign mem_addr     = (state_q == ACCESS) ? addr_q  : '0;
   assign mem_wdata    = (state_q == ACCESS) ? wdata_q : '0;
   assign r0_rdata     = rd0_q;
   assign r1_rdata     = rd1_q;
   assign busy         = (state_q != IDLE);
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors feed expected
// grants/read responses into queues checked by a negedge monitor.
module tb_dmem_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;

   typedef struct {
      bit          p;
      bit          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } gexp_t;

   typedef struct {
      bit          p;
      logic [DW-1:0] d;
   } rexp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
   logic [AW-1:0] r0_addr = 0, r1_addr = 0;
   logic [DW-1:0] r0_wdata = 0, r1_wdata = 0;
   logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          mem_re, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [7:0]    conflict_cnt;

   logic [DW-1:0] mem [64];
   gexp_t gq[$];
   rexp_t rq[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
      .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
      .r1_rdata(r1_rdata),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .conflict_cnt(conflict_cnt)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk)
      if (mem_we) mem[mem_addr] <= mem_wdata;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_acc(input bit p, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      gexp_t g;
      rexp_t r;
      g.p = p; g.we = we; g.a = a; g.d = d;
      gq.push_back(g);
      if (!we) begin
         r.p = p; r.d = d;
         rq.push_back(r);
      end
   endtask

   task automatic wait_gnt(input string nm, output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (r0_gnt || r1_gnt) begin
            n = i;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s: got no grant expected grant within 20 cycles", nm);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_cnt", conflict_cnt, 0);
      chk("rst_rd0", r0_rdata, 0);
      chk("rst_rd1", r1_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor: invariants every cycle, scoreboard pops on gnt/rvalid
   always @(negedge clk) begin
      if (!rst) begin
         chk("one_hot", {30'd0, (r0_gnt && r1_gnt) ||
             (r0_rvalid && r1_rvalid), mem_re && mem_we}, 0);
         if (r0_gnt || r1_gnt) begin
            if (gq.size() == 0) begin
               chk("unexp_gnt", {r1_gnt, r0_gnt}, 0);
            end else begin
               gexp_t e;
               e = gq.pop_front();
               chk("gnt_port", r1_gnt, e.p);
               chk("gnt_we", mem_we, e.we);
               chk("gnt_re", mem_re, !e.we);
               chk("gnt_addr", mem_addr, e.a);
               if (e.we) chk("gnt_wdata", mem_wdata, e.d);
            end
         end
         if (r0_rvalid || r1_rvalid) begin
            if (rq.size() == 0) begin
               chk("unexp_rv", {r1_rvalid, r0_rvalid}, 0);
            end else begin
               rexp_t e;
               e = rq.pop_front();
               chk("rv_port", r1_rvalid, e.p);
               chk("rv_data", r1_rvalid ? r1_rdata : r0_rdata, e.d);
            end
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      #1 rst = 1'b1;
      #1;
      chk("init_gnt", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, 0);
      chk("init_mem", {mem_re, mem_we}, 0);
      chk("init_addr", mem_addr, 0);
      chk("init_wdata", mem_wdata, 0);
      chk("init_busy", busy, 0);
      chk("init_cnt", conflict_cnt, 0);
      chk("init_rd", r0_rdata | r1_rdata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // port 1 write addr 5
      @(negedge clk);
      r1_req = 1; r1_we = 1; r1_addr = 5; r1_wdata = 32'hDEADBEEF;
      exp_acc(1, 1, 5, 32'hDEADBEEF);
      wait_gnt("w1", n);
      chk("w1_lat", n, 1);
      r1_req = 0; r1_we = 0;
      repeat (3) @(negedge clk);
      chk("w1_mem", mem[5], 32'hDEADBEEF);

      // port 0 read addr 5
      r0_req = 1; r0_we = 0; r0_addr = 5;
      exp_acc(0, 0, 5, 32'hDEADBEEF);
      wait_gnt("r0", n);
      chk("r0_lat", n, 1);
      r0_req = 0;
      @(negedge clk);
      chk("r0_rv_lat", r0_rvalid, 1);
      repeat (4) @(negedge clk);
      chk("r0_hold", r0_rdata, 32'hDEADBEEF);

      // both continuous: alternating grants, counting conflicts
      do_reset();
      r0_req = 1; r0_we = 0; r0_addr = 5;
      r1_req = 1; r1_we = 1; r1_addr = 7; r1_wdata = 32'h12345678;
      for (int i = 0; i < 4; i++)
         if (i % 2 == 0) exp_acc(0, 0, 5, 32'hDEADBEEF);
         else            exp_acc(1, 1, 7, 32'h12345678);
      for (int i = 0; i < 4; i++) begin
         wait_gnt("alt", n);
         chk("alt_cnt", conflict_cnt, i + 1);
      end
      r0_req = 0; r1_req = 0; r1_we = 0;
      repeat (4) @(negedge clk);
      chk("alt_mem7", mem[7], 32'h12345678);
      chk("alt_rd0", r0_rdata, 32'hDEADBEEF);
      chk("alt_idle", busy, 0);

      // grant port 0 so the pointer moves to port 1
      r0_req = 1; r0_we = 1; r0_addr = 9; r0_wdata = 32'hA5A5A5A5;
      exp_acc(0, 1, 9, 32'hA5A5A5A5);
      wait_gnt("w0", n);
      r0_req = 0;
      repeat (3) @(negedge clk);

      // reset during a port 0 write access
      r0_req = 1; r0_we = 1; r0_addr = 10; r0_wdata = 32'h5A5A5A5A;
      @(posedge clk);
      #1;
      chk("ab_we_pre", mem_we, 1);
      rst = 1'b1;
      #1;
      chk("ab_we", mem_we, 0);
      chk("ab_gnt", r0_gnt, 0);
      chk("ab_busy", busy, 0);
      chk("ab_addr", mem_addr, 0);
      r0_req = 0; r0_we = 0;
      @(negedge clk);
      rst = 1'b0;
      chk("ab_mem10", mem[10], 0);
      // both request: reset pointer means port 0 wins first
      r0_req = 1; r0_addr = 5;
      r1_req = 1; r1_we = 0; r1_addr = 5;
      exp_acc(0, 0, 5, 32'hDEADBEEF);
      exp_acc(1, 0, 5, 32'hDEADBEEF);
      wait_gnt("ptr0", n);
      chk("ptr0_lat", n, 1);
      chk("ptr0_port", r0_gnt, 1);
      wait_gnt("ptr1", n);
      r0_req = 0; r1_req = 0;
      repeat (3) @(negedge clk);

      // port 0 pulse inside RESP only: never granted
      r1_req = 1; r1_we = 0; r1_addr = 5;
      exp_acc(1, 0, 5, 32'hDEADBEEF);
      wait_gnt("pl", n);
      r1_req = 0;
      @(posedge clk);
      #1;
      r0_req = 1; r0_we = 1; r0_addr = 3; r0_wdata = 32'h1;
      @(negedge clk);
      r0_req = 0; r0_we = 0;
      @(posedge clk);
      #1;
      chk("pl_idle", busy, 0);
      repeat (3) @(negedge clk);
      chk("pl_mem3", mem[3], 0);

      // 300 conflicts saturate the counter
      do_reset();
      r0_req = 1; r0_we = 0; r0_addr = 5;
      r1_req = 1; r1_we = 0; r1_addr = 5;
      for (int i = 0; i < 300; i++)
         exp_acc(i[0], 0, 5, 32'hDEADBEEF);
      for (int i = 0; i < 300; i++) begin
         wait_gnt("sat", n);
         if (i == 0)   chk("sat_1", conflict_cnt, 1);
         if (i == 254) chk("sat_255", conflict_cnt, 255);
         if (i == 255) chk("sat_hold", conflict_cnt, 255);
      end
      r0_req = 0; r1_req = 0;
      repeat (4) @(negedge clk);
      chk("sat_end", conflict_cnt, 255);

      chk("gq_empty", gq.size(), 0);
      chk("rq_empty", rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
